param_ping_pong_counter: RTL

Parametrised bidirectional (ping-pong) counter. It counts up to an upper bound, reverses, counts down to a lower bound, reverses, and repeats. It generalises the lab's fixed 4-bit ping-pong counter with configurable width, runtime bounds, a forced-reversal input and a bound-hit pulse. It feeds the display/scoreboard datapath as a free-running or gated sweep source.

---
 rtl/param_ping_pong_counter_pkg.sv | 14 +
 rtl/param_ping_pong_counter_bounds.sv | 62 ++++++
 rtl/param_ping_pong_counter.sv | 91 +++++++++
 3 files changed

// File: rtl/param_ping_pong_counter_pkg.sv
// Shared definitions for the ping-pong counter: direction encoding and the
// default upper bound for a given counter width.
package ppc_pkg;

    // Direction encoding used by the counter and its bound logic.
    localparam logic PPC_UP   = 1'b1;
    localparam logic PPC_DOWN = 1'b0;

    // All-ones value for a counter of the given width (valid up to 63 bits).
    function automatic logic [63:0] ppc_default_hi(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/param_ping_pong_counter_bounds.sv
// Bound registers for the ping-pong counter.
// With PPC_BOUND_LOAD_EN defined, lo/hi are loadable registers and a write with
// min > max is rejected with a one-cycle bound_err pulse. Without the macro the
// bounds collapse to the full range and bound_err is tied low.
module ppc_bounds
    import ppc_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bound_we,
    input  logic [WIDTH-1:0] i_bound_min,
    input  logic [WIDTH-1:0] i_bound_max,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_bound_err
);

    localparam logic [WIDTH-1:0] HI_DEFAULT = WIDTH'(ppc_default_hi(WIDTH));

`ifdef PPC_BOUND_LOAD_EN
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_bound_err;
    logic             w_bounds_ok;

    assign w_bounds_ok = (i_bound_min <= i_bound_max);

    // Accept ordered bound pairs, flag and drop inverted ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lo        <= '0;
            r_hi        <= HI_DEFAULT;
            r_bound_err <= 1'b0;
        end else begin
            r_bound_err <= 1'b0;
            if (i_bound_we) begin
                if (w_bounds_ok) begin
                    r_lo <= i_bound_min;
                    r_hi <= i_bound_max;
                end else begin
                    r_bound_err <= 1'b1;
                end
            end
        end
    end

    assign o_lo        = r_lo;
    assign o_hi        = r_hi;
    assign o_bound_err = r_bound_err;
`else
    // Inputs are kept on the port list so the interface is build-independent.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{i_clk, i_rst, i_bound_we, i_bound_min, i_bound_max};

    assign o_lo        = '0;
    assign o_hi        = HI_DEFAULT;
    assign o_bound_err = 1'b0;
`endif

endmodule

// File: rtl/param_ping_pong_counter.sv
// Parametrised ping-pong counter: sweeps between lo and hi, reversing at each
// bound with a one-cycle turn pulse, with a forced-reversal input (flip).
// Optional runtime bound loading is enabled by defining PPC_BOUND_LOAD_EN.
//
// Handshake: there is no valid/ready pair; enable is a level qualifier sampled
// at every rising edge, and bound_we is a single-cycle write strobe that is
// always accepted (a rejected write is reported through bound_err).
module param_ping_pong_counter
    import ppc_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flip,
    input  logic             bound_we,
    input  logic [WIDTH-1:0] bound_min,
    input  logic [WIDTH-1:0] bound_max,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic             turn,
    output logic             bound_err
);

    logic [WIDTH-1:0] r_out;
    logic             r_direction;
    logic             r_turn;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_bound_err;
    logic             w_dir_eff;

    ppc_bounds #(
        .WIDTH (WIDTH)
    ) u_bounds (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_bound_we  (bound_we),
        .i_bound_min (bound_min),
        .i_bound_max (bound_max),
        .o_lo        (w_lo),
        .o_hi        (w_hi),
        .o_bound_err (w_bound_err)
    );

    // flip inverts the direction used for this step only.
    assign w_dir_eff = r_direction ^ flip;

    // Count step; the bounds seen here are the ones before any same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= RST_VAL;
            r_direction <= PPC_UP;
            r_turn      <= 1'b0;
        end else if (enable) begin
            r_turn <= 1'b0;
            if (w_hi == w_lo) begin
                // Degenerate range: park on the single legal value.
                r_out <= w_lo;
            end else if (r_out > w_hi) begin
                // Out of range after a bound change: clamp and head back in.
                r_out       <= w_hi;
                r_direction <= PPC_DOWN;
            end else if (r_out < w_lo) begin
                r_out       <= w_lo;
                r_direction <= PPC_UP;
            end else if ((w_dir_eff == PPC_UP) && (r_out == w_hi)) begin
                r_out       <= w_hi - 1'b1;
                r_direction <= PPC_DOWN;
                r_turn      <= 1'b1;
            end else if ((w_dir_eff == PPC_DOWN) && (r_out == w_lo)) begin
                r_out       <= w_lo + 1'b1;
                r_direction <= PPC_UP;
                r_turn      <= 1'b1;
            end else begin
                r_out       <= (w_dir_eff == PPC_UP) ? r_out + 1'b1 : r_out - 1'b1;
                r_direction <= w_dir_eff;
            end
        end else begin
            r_turn <= 1'b0;
        end
    end

    assign out       = r_out;
    assign direction = r_direction;
    assign turn      = r_turn;
    assign bound_err = w_bound_err;

endmodule
